vending_ctrl_multi: RTL and testbench

Parametrised multi-item vending controller; successor to the fixed two-drink machine.
Supports NUM_ITEMS products with a parameter price table and a bounded credit accumulator.
Vending uses a ready/valid handshake to a dispenser, and change is paid out coin-by-coin (greedy 20/10/5) over a second handshake.
Sits between the coin acceptor and the product and coin dispensers.

---
 rtl/vending_ctrl_multi_pkg.sv | 27 ++
 rtl/vending_ctrl_multi_if.sv | 37 +++
 rtl/vending_ctrl_multi_change_payout.sv | 49 ++++
 rtl/vending_ctrl_multi.sv | 146 ++++++++++++++
 tb/tb_vending_ctrl_multi.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vending_ctrl_multi_pkg.sv
// Shared definitions for the multi-item vending controller: coin codes,
// controller states and the coin-value lookup.
package vending_ctrl_multi_pkg;

   typedef logic [1:0] coin_t;

   localparam coin_t COIN_5   = 2'd0;
   localparam coin_t COIN_10  = 2'd1;
   localparam coin_t COIN_20  = 2'd2;
   localparam coin_t COIN_INV = 2'd3;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_VEND    = 2'd1,
      ST_CHANGE  = 2'd2
   } state_t;

   function automatic logic [4:0] coinValue(input coin_t code);
      case (code)
         COIN_5:  return 5'd5;
         COIN_10: return 5'd10;
         COIN_20: return 5'd20;
         default: return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/vending_ctrl_multi_if.sv
// Bundle of coin, selection, vend and change signals around the controller.
// The slave modport is the controller's view; master is the machine around it.
interface vending_ctrl_multi_if #(
   parameter int NUM_ITEMS = 4,
   parameter int CREDIT_W  = 8
);
   localparam int IDX_W = $clog2(NUM_ITEMS);

   logic                coin_valid;
   logic [1:0]          coin_type;
   logic                coin_accept;
   logic                coin_reject;
   logic                sel_valid;
   logic [IDX_W-1:0]    sel_item;
   logic                sel_error;
   logic                cancel;
   logic                vend_valid;
   logic [IDX_W-1:0]    vend_item;
   logic                vend_ready;
   logic                chg_valid;
   logic [1:0]          chg_type;
   logic                chg_ready;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   modport slave (
      input  coin_valid, coin_type, sel_valid, sel_item, cancel, vend_ready, chg_ready,
      output coin_accept, coin_reject, sel_error, vend_valid, vend_item,
             chg_valid, chg_type, credit, busy
   );

   modport master (
      output coin_valid, coin_type, sel_valid, sel_item, cancel, vend_ready, chg_ready,
      input  coin_accept, coin_reject, sel_error, vend_valid, vend_item,
             chg_valid, chg_type, credit, busy
   );
endinterface

// File: rtl/vending_ctrl_multi_change_payout.sv
// Pays a latched refund out one coin at a time, largest coin first, over a
// valid/ready handshake; done pulses on the handshake that empties the refund.
module change_payout
   import vending_ctrl_multi_pkg::*;
#(
   parameter int CREDIT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic [CREDIT_W-1:0] loadValue_i,
   input  logic                chgReady_i,
   output logic                chgValid_o,
   output coin_t               chgType_o,
   output logic                done_o
);

   logic [CREDIT_W-1:0] refund_q, refund_d;
   logic [CREDIT_W-1:0] remaining;

   // Refunds are always multiples of 5, so COIN_5 covers anything below 10.
   always_comb begin
      chgType_o = COIN_5;
      if (refund_q >= CREDIT_W'(20))
         chgType_o = COIN_20;
      else if (refund_q >= CREDIT_W'(10))
         chgType_o = COIN_10;
   end

   assign chgValid_o = (refund_q != '0);
   assign remaining  = refund_q - CREDIT_W'(coinValue(chgType_o));
   assign done_o     = chgValid_o && chgReady_i && (remaining == '0);

   always_comb begin
      refund_d = refund_q;
      if (load_i)
         refund_d = loadValue_i;
      else if (chgValid_o && chgReady_i)
         refund_d = remaining;
   end

   always_ff @(posedge clk) begin
      if (!reset)
         refund_q <= '0;
      else
         refund_q <= refund_d;
   end

endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-item vending controller: credit accumulation, product selection and
// vend handshake; change payout is delegated to change_payout.
module vending_ctrl_multi
   import vending_ctrl_multi_pkg::*;
#(
   parameter int                          NUM_ITEMS  = 4,
   parameter int                          CREDIT_W   = 8,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES   = {8'd30, 8'd25, 8'd15, 8'd10},
   parameter int                          MAX_CREDIT = 100
) (
   input  logic               clk,
   input  logic               reset,
   vending_ctrl_multi_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_ITEMS);
   localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

   function automatic bit pricesOk();
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (PRICES[i*CREDIT_W +: CREDIT_W] == '0 || (PRICES[i*CREDIT_W +: CREDIT_W] % 5) != 0)
            return 1'b0;
      end
      return 1'b1;
   endfunction

   if (!pricesOk() || (MAX_CREDIT % 5) != 0 || MAX_CREDIT >= 2**CREDIT_W) begin : gBadConfig
      $fatal(1, "vending_ctrl_multi: prices and MAX_CREDIT must be nonzero multiples of 5 within CREDIT_W");
   end

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [IDX_W-1:0]    vendItem_q, vendItem_d;
   logic                vendValid_q, vendValid_d;
   logic                coinAccept_q, coinAccept_d;
   logic                coinReject_q, coinReject_d;
   logic                selError_q, selError_d;
   logic                refundLoad;
   logic                chgDone;
   logic                idxOk;
   logic [CREDIT_W-1:0] price;
   logic [CREDIT_W:0]   coinSum;

   always_comb begin
      price = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (bus.sel_item == IDX_W'(i))
            price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
   end

   // One extra bit so a coin on top of near-maximum credit cannot wrap.
   assign idxOk   = ({1'b0, bus.sel_item} < (IDX_W+1)'(NUM_ITEMS));
   assign coinSum = {1'b0, credit_q} + (CREDIT_W+1)'(coinValue(bus.coin_type));

   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      vendItem_d   = vendItem_q;
      vendValid_d  = vendValid_q;
      coinAccept_d = 1'b0;
      coinReject_d = bus.coin_valid;
      selError_d   = 1'b0;
      refundLoad   = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            if (bus.cancel && credit_q != '0) begin
               refundLoad = 1'b1;
               credit_d   = '0;
               state_d    = ST_CHANGE;
            end else if (bus.sel_valid && idxOk && credit_q >= price) begin
               credit_d    = credit_q - price;
               vendItem_d  = bus.sel_item;
               vendValid_d = 1'b1;
               state_d     = ST_VEND;
            end else begin
               selError_d = bus.sel_valid;
               if (bus.coin_valid && !bus.cancel && bus.coin_type != COIN_INV && coinSum <= MAX_SUM) begin
                  coinAccept_d = 1'b1;
                  coinReject_d = 1'b0;
                  credit_d     = coinSum[CREDIT_W-1:0];
               end
            end
         end
         ST_VEND: begin
            if (vendValid_q && bus.vend_ready) begin
               vendValid_d = 1'b0;
               if (credit_q != '0) begin
                  refundLoad = 1'b1;
                  credit_d   = '0;
                  state_d    = ST_CHANGE;
               end else begin
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_CHANGE: begin
            if (chgDone)
               state_d = ST_COLLECT;
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_COLLECT;
         credit_q     <= '0;
         vendItem_q   <= '0;
         vendValid_q  <= 1'b0;
         coinAccept_q <= 1'b0;
         coinReject_q <= 1'b0;
         selError_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         vendItem_q   <= vendItem_d;
         vendValid_q  <= vendValid_d;
         coinAccept_q <= coinAccept_d;
         coinReject_q <= coinReject_d;
         selError_q   <= selError_d;
      end
   end

   change_payout #(
      .CREDIT_W (CREDIT_W)
   ) uPayout (
      .clk         (clk),
      .reset       (reset),
      .load_i      (refundLoad),
      .loadValue_i (credit_q),
      .chgReady_i  (bus.chg_ready),
      .chgValid_o  (bus.chg_valid),
      .chgType_o   (bus.chg_type),
      .done_o      (chgDone)
   );

   assign bus.coin_accept = coinAccept_q;
   assign bus.coin_reject = coinReject_q;
   assign bus.sel_error   = selError_q;
   assign bus.vend_valid  = vendValid_q;
   assign bus.vend_item   = vendItem_q;
   assign bus.credit      = credit_q;
   assign bus.busy        = (state_q != ST_COLLECT);

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Scoreboard bench for vending_ctrl_multi: stimulus queues expected coin,
// sel_error, vend and change events; a negedge monitor pops and compares them.
module tb_vending_ctrl_multi;

   localparam logic [1:0] C5  = 2'd0;
   localparam logic [1:0] C10 = 2'd1;
   localparam logic [1:0] C20 = 2'd2;
   localparam logic [1:0] CINV = 2'd3;

   logic clk;
   logic reset;
   int   tests;
   int   failed;

   bit         coinQ[$];
   bit         selErrQ[$];
   logic [1:0] vendQ[$];
   logic [1:0] chgQ[$];

   vending_ctrl_multi_if #(.NUM_ITEMS(4), .CREDIT_W(8)) vif ();

   vending_ctrl_multi #(
      .NUM_ITEMS  (4),
      .CREDIT_W   (8),
      .PRICES     ({8'd30, 8'd25, 8'd15, 8'd10}),
      .MAX_CREDIT (100)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (vif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired tests=%0d failed=%0d", tests, failed);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAtNeg(input string name, input int actual, input int expected);
      @(negedge clk);
      checkOutput(name, actual, expected);
   endtask

   // Monitor: every DUT-presented event is matched against the scoreboard.
   always @(negedge clk) begin
      if (vif.coin_accept || vif.coin_reject) begin
         if (coinQ.size() == 0) checkOutput("coin_unexpected", int'(coinQ.size()), 1);
         else begin
            automatic bit exp = coinQ.pop_front();
            checkOutput("coin_accept", vif.coin_accept, exp);
            checkOutput("coin_reject", vif.coin_reject, !exp);
         end
      end
      if (vif.sel_error) begin
         if (selErrQ.size() == 0) checkOutput("sel_error_unexpected", int'(selErrQ.size()), 1);
         else void'(selErrQ.pop_front());
      end
      if (vif.vend_valid && vif.vend_ready) begin
         if (vendQ.size() == 0) checkOutput("vend_unexpected", int'(vendQ.size()), 1);
         else checkOutput("vend_item", vif.vend_item, vendQ.pop_front());
      end
      if (vif.chg_valid && vif.chg_ready) begin
         if (chgQ.size() == 0) checkOutput("chg_unexpected", int'(chgQ.size()), 1);
         else checkOutput("chg_type", vif.chg_type, chgQ.pop_front());
      end
   end

   task automatic applyStimulus(input bit coinV, input logic [1:0] ctype, input bit selV,
                                input logic [1:0] item, input bit cancelV);
      vif.coin_valid = coinV;
      vif.coin_type  = ctype;
      vif.sel_valid  = selV;
      vif.sel_item   = item;
      vif.cancel     = cancelV;
      tick();
      vif.coin_valid = 1'b0;
      vif.sel_valid  = 1'b0;
      vif.cancel     = 1'b0;
   endtask

   task automatic insertCoin(input logic [1:0] ctype, input bit expAccept);
      coinQ.push_back(expAccept);
      applyStimulus(1'b1, ctype, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic vendHandshake();
      int n = 0;
      while (!vif.vend_valid && n < 20) begin tick(); n++; end
      checkOutput("vend_valid_seen", vif.vend_valid, 1);
      vif.vend_ready = 1'b1;
      tick();
      vif.vend_ready = 1'b0;
   endtask

   task automatic drainChange();
      int n = 0;
      vif.chg_ready = 1'b1;
      while (vif.chg_valid && n < 20) begin tick(); n++; end
      vif.chg_ready = 1'b0;
      checkAtNeg("chg_drained", vif.chg_valid, 0);
      checkOutput("busy_after_change", vif.busy, 0);
   endtask

   initial begin
      tests = 0;
      failed = 0;
      reset = 1'b0;
      vif.coin_valid = 1'b0; vif.coin_type = 2'd0;
      vif.sel_valid = 1'b0;  vif.sel_item = 2'd0;
      vif.cancel = 1'b0;     vif.vend_ready = 1'b0; vif.chg_ready = 1'b0;
      repeat (3) tick();
      checkAtNeg("reset_credit", vif.credit, 0);
      checkOutput("reset_busy", vif.busy, 0);
      checkOutput("reset_vend_valid", vif.vend_valid, 0);
      checkOutput("reset_chg_valid", vif.chg_valid, 0);
      checkOutput("reset_coin_accept", vif.coin_accept, 0);
      tick();
      reset = 1'b1;

      // Prices: item0=10 item1=15 item2=25 item3=30
      insertCoin(C10, 1'b1);
      checkAtNeg("t1_credit10", vif.credit, 10);
      tick();
      insertCoin(C20, 1'b1);
      checkAtNeg("t1_credit30", vif.credit, 30);
      tick();
      vendQ.push_back(2'd2);
      applyStimulus(1'b0, C5, 1'b1, 2'd2, 1'b0);
      checkAtNeg("t1_credit5", vif.credit, 5);
      checkOutput("t1_busy", vif.busy, 1);
      tick();
      vendHandshake();
      chgQ.push_back(C5);
      checkAtNeg("t1_credit_in_change", vif.credit, 0);
      tick();
      drainChange();
      tick();

      insertCoin(C20, 1'b1);
      selErrQ.push_back(1'b1);
      applyStimulus(1'b0, C5, 1'b1, 2'd3, 1'b0);
      checkAtNeg("t2_sel_error", vif.sel_error, 1);
      checkOutput("t2_credit20", vif.credit, 20);
      tick();
      checkAtNeg("t2_sel_error_one_pulse", vif.sel_error, 0);
      tick();
      chgQ.push_back(C20);
      applyStimulus(1'b0, C5, 1'b0, 2'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checkAtNeg("t2_hold_valid", vif.chg_valid, 1);
         checkOutput("t2_hold_type", vif.chg_type, C20);
         tick();
      end
      drainChange();
      tick();

      for (int i = 0; i < 4; i++) insertCoin(C20, 1'b1);
      insertCoin(C10, 1'b1);
      checkAtNeg("t3_credit90", vif.credit, 90);
      tick();
      insertCoin(C20, 1'b0);
      checkAtNeg("t3_credit_still90", vif.credit, 90);
      tick();
      insertCoin(C10, 1'b1);
      checkAtNeg("t3_credit100", vif.credit, 100);
      tick();
      insertCoin(CINV, 1'b0);
      insertCoin(C5, 1'b0);
      checkAtNeg("t3_credit_max", vif.credit, 100);
      tick();
      for (int i = 0; i < 5; i++) chgQ.push_back(C20);
      applyStimulus(1'b0, C5, 1'b0, 2'd0, 1'b1);
      drainChange();
      tick();

      insertCoin(C10, 1'b1);
      insertCoin(C5, 1'b1);
      coinQ.push_back(1'b0);
      vendQ.push_back(2'd0);
      applyStimulus(1'b1, C5, 1'b1, 2'd0, 1'b0);
      checkAtNeg("t4_credit5", vif.credit, 5);
      tick();
      vendHandshake();
      chgQ.push_back(C5);
      drainChange();
      tick();
      insertCoin(C10, 1'b1);
      coinQ.push_back(1'b0);
      chgQ.push_back(C10);
      applyStimulus(1'b1, C10, 1'b0, 2'd0, 1'b1);
      checkAtNeg("t4_cancel_credit0", vif.credit, 0);
      tick();
      drainChange();
      tick();

      insertCoin(C20, 1'b1);
      vendQ.push_back(2'd0);
      applyStimulus(1'b0, C5, 1'b1, 2'd0, 1'b0);
      insertCoin(C10, 1'b0);
      applyStimulus(1'b0, C5, 1'b1, 2'd1, 1'b1);
      checkAtNeg("t5_vend_credit", vif.credit, 10);
      checkOutput("t5_vend_item", vif.vend_item, 0);
      checkOutput("t5_vend_busy", vif.busy, 1);
      tick();
      vendHandshake();
      chgQ.push_back(C10);
      insertCoin(C10, 1'b0);
      applyStimulus(1'b0, C5, 1'b1, 2'd0, 1'b1);
      checkAtNeg("t5_change_credit", vif.credit, 0);
      checkOutput("t5_change_valid", vif.chg_valid, 1);
      checkOutput("t5_change_type", vif.chg_type, C10);
      tick();
      drainChange();
      tick();

      insertCoin(C20, 1'b1);
      insertCoin(C10, 1'b1);
      insertCoin(C5, 1'b1);
      chgQ.push_back(C20); chgQ.push_back(C10); chgQ.push_back(C5);
      applyStimulus(1'b0, C5, 1'b0, 2'd0, 1'b1);
      drainChange();
      tick();
      insertCoin(C20, 1'b1);
      insertCoin(C20, 1'b1);
      applyStimulus(1'b0, C5, 1'b0, 2'd0, 1'b1);
      chgQ.push_back(C20);
      vif.chg_ready = 1'b1;
      tick();
      vif.chg_ready = 1'b0;
      checkAtNeg("t6_mid_change_valid", vif.chg_valid, 1);
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checkAtNeg("t6_reset_chg_valid", vif.chg_valid, 0);
      checkOutput("t6_reset_credit", vif.credit, 0);
      checkOutput("t6_reset_busy", vif.busy, 0);
      tick();
      insertCoin(C5, 1'b1);
      checkAtNeg("t6_after_reset_credit", vif.credit, 5);
      tick();
      tick();

      checkOutput("coinQ_left", int'(coinQ.size()), 0);
      checkOutput("selErrQ_left", int'(selErrQ.size()), 0);
      checkOutput("vendQ_left", int'(vendQ.size()), 0);
      checkOutput("chgQ_left", int'(chgQ.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
